// File: rtl/comm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comm_pkg
//  Description : Shared constants and helpers for the block interleaver.
//                INTLV_ROWS/INTLV_COLS : default matrix geometry.
//                ODD_FIRST             : odd encoder bit goes to the even
//                                        (lower) address of each pair.
//                intlv_rd_addr()       : column-major read index -> row-major
//                                        storage address.
//  Revision    : 1.0 - initial release
// ============================================================================
package comm_pkg;

  localparam int INTLV_ROWS = 8;
  localparam int INTLV_COLS = 16;
  localparam bit ODD_FIRST  = 1'b1;

  // Serial index k walks down a column first: r = k mod rows, c = k / rows.
  function automatic int intlv_rd_addr(input int k, input int rows, input int cols);
    return (k % rows) * cols + (k / rows);
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_interleaver_if.sv
`default_nettype none
// ============================================================================
//  Module      : block_interleaver_if
//  Description : Handshake bundle between encoder, interleaver and modulator.
//                in_valid/in_odd/in_even/in_ready : encoded pair input
//                out_bit/out_valid/out_ready/out_last : serial output
//                master : the environment (encoder + modulator side)
//                slave  : the interleaver
//  Revision    : 1.0 - initial release
// ============================================================================
interface block_interleaver_if;

  logic in_valid;
  logic in_odd;
  logic in_even;
  logic in_ready;
  logic out_bit;
  logic out_valid;
  logic out_ready;
  logic out_last;

  modport master (
    output in_valid, in_odd, in_even, out_ready,
    input  in_ready, out_bit, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_odd, in_even, out_ready,
    output in_ready, out_bit, out_valid, out_last
  );

endinterface
`default_nettype wire

// File: rtl/intlv_bank.sv
`default_nettype none
// ============================================================================
//  Module      : intlv_bank
//  Description : One ROWS*COLS bit store. Two-bit write port, one-bit
//                combinational read port. Contents are not reset.
//                clk      : clock
//                we_i     : write enable for both write lanes
//                waddr0_i : address of lane 0,  wdata_i[0]
//                waddr1_i : address of lane 1,  wdata_i[1]
//                raddr_i  : read address
//                rdata_o  : read data
//  Revision    : 1.0 - initial release
// ============================================================================
module intlv_bank #(
  parameter int ROWS = 8,
  parameter int COLS = 16
) (
  input  logic                             clk,
  input  logic                             we_i,
  input  logic [$clog2(ROWS*COLS)-1:0]     waddr0_i,
  input  logic [$clog2(ROWS*COLS)-1:0]     waddr1_i,
  input  logic [1:0]                       wdata_i,
  input  logic [$clog2(ROWS*COLS)-1:0]     raddr_i,
  output logic                             rdata_o
);

  localparam int NBITS = ROWS * COLS;

  logic [NBITS-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr0_i] <= wdata_i[0];
      mem_q[waddr1_i] <= wdata_i[1];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/block_interleaver.sv
`default_nettype none
// ============================================================================
//  Module      : block_interleaver
//  Description : Ping-pong ROWS x COLS block interleaver. Encoded bit pairs
//                are written row-major into one bank while the other bank is
//                read out serially column-major.
//                clk      : system clock
//                reset    : asynchronous reset, active low
//                flush    : synchronous clear of all blocks and flags
//                bus      : pair input / serial output handshakes
//                overflow : sticky, a pair arrived while in_ready was 0
//  Revision    : 1.0 - initial release
// ============================================================================
module block_interleaver
  import comm_pkg::*;
#(
  parameter int ROWS = INTLV_ROWS,
  parameter int COLS = INTLV_COLS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  block_interleaver_if.slave  bus,
  output logic                overflow
);

  localparam int NBITS  = ROWS * COLS;
  localparam int NPAIRS = NBITS / 2;
  localparam int AW     = $clog2(NBITS);
  localparam int PW     = $clog2(NPAIRS);

  localparam logic [AW-1:0] LAST_BIT  = AW'(NBITS - 1);
  localparam logic [PW-1:0] LAST_PAIR = PW'(NPAIRS - 1);

  // Control state
  logic [PW-1:0] wr_cnt_q,    wr_cnt_d;
  logic [AW-1:0] rd_cnt_q,    rd_cnt_d;
  logic          wr_bank_q,   wr_bank_d;
  logic          rd_bank_q,   rd_bank_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          overflow_q,  overflow_d;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_accept;
  logic          w_xfer;
  logic          w_last;
  logic [1:0]    w_we;
  logic [1:0]    w_wdata;
  logic [1:0]    w_rdata;
  logic [AW-1:0] w_waddr0;
  logic [AW-1:0] w_waddr1;
  logic [AW-1:0] w_raddr;

  always_comb begin
    w_in_ready  = ~bank_full_q[wr_bank_q];
    w_out_valid = bank_full_q[rd_bank_q];
    w_accept    = bus.in_valid & w_in_ready;
    w_xfer      = w_out_valid & bus.out_ready;
    w_last      = w_out_valid & (rd_cnt_q == LAST_BIT);
  end

  // Pair p occupies addresses 2p and 2p+1 of the row-major matrix.
  assign w_waddr0 = {wr_cnt_q, 1'b0};
  assign w_waddr1 = {wr_cnt_q, 1'b1};
  assign w_wdata  = ODD_FIRST ? {bus.in_even, bus.in_odd} : {bus.in_odd, bus.in_even};
  assign w_raddr  = AW'(intlv_rd_addr(int'(rd_cnt_q), ROWS, COLS));

  // Writes are suppressed on flush; the stale data is harmless anyway
  // because bank_full is cleared.
  assign w_we[0] = w_accept & ~flush & ~wr_bank_q;
  assign w_we[1] = w_accept & ~flush &  wr_bank_q;

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    bank_full_d = bank_full_q;
    overflow_d  = overflow_q;

    if (flush) begin
      wr_cnt_d    = '0;
      rd_cnt_d    = '0;
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      bank_full_d = 2'b00;
      overflow_d  = 1'b0;
    end else begin
      if (w_accept) begin
        if (wr_cnt_q == LAST_PAIR) begin
          bank_full_d[wr_bank_q] = 1'b1;
          wr_bank_d              = ~wr_bank_q;
          wr_cnt_d               = '0;
        end else begin
          wr_cnt_d = wr_cnt_q + PW'(1);
        end
      end

      // A set needs the bank empty and a clear needs it full, so the two
      // updates above and below never target the same bank in one cycle.
      if (w_xfer) begin
        if (w_last) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = ~rd_bank_q;
          rd_cnt_d               = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + AW'(1);
        end
      end

      if (bus.in_valid & ~w_in_ready) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      overflow_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
    end
  end

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      intlv_bank #(
        .ROWS (ROWS),
        .COLS (COLS)
      ) u_bank (
        .clk      (clk),
        .we_i     (w_we[b]),
        .waddr0_i (w_waddr0),
        .waddr1_i (w_waddr1),
        .wdata_i  (w_wdata),
        .raddr_i  (w_raddr),
        .rdata_o  (w_rdata[b])
      );
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_bit   = w_out_valid & w_rdata[rd_bank_q];
  assign bus.out_last  = w_last;
  assign overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_block_interleaver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_block_interleaver
//  Description : Directed self-checking bench for block_interleaver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_block_interleaver;

  localparam int ROWS   = 8;
  localparam int COLS   = 16;
  localparam int NBITS  = ROWS * COLS;
  localparam int NPAIRS = NBITS / 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic overflow;

  block_interleaver_if bus ();

  block_interleaver #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  typedef struct {
    int pair;
    bit use_even;
    int exp_k;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference permutation: serial bit k comes from row k%ROWS, column k/ROWS.
  function automatic logic [NBITS-1:0] interleave(input logic [NBITS-1:0] d);
    logic [NBITS-1:0] o;
    for (int k = 0; k < NBITS; k++) o[k] = d[(k % ROWS) * COLS + (k / ROWS)];
    return o;
  endfunction

  function automatic logic [NBITS-1:0] rand_block();
    logic [NBITS-1:0] d;
    for (int i = 0; i < NBITS / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // All tasks start and end at posedge + 1.
  task automatic push_pair(input logic odd, input logic even, output bit acc);
    bus.in_valid = 1'b1;
    bus.in_odd   = odd;
    bus.in_even  = even;
    acc          = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic load_block(input logic [NBITS-1:0] d, output int nacc);
    bit a;
    nacc = 0;
    for (int i = 0; i < NPAIRS; i++) begin
      push_pair(d[2*i], d[2*i+1], a);
      nacc += int'(a);
    end
  endtask

  task automatic collect(input int n, output logic [NBITS-1:0] bits, output int nlast,
                         output int last_idx, output bit rdy_at_last, output bit tmo);
    int idx = 0;
    int cyc = 0;
    bits = '0; nlast = 0; last_idx = -1; rdy_at_last = 1'b1;
    bus.out_ready = 1'b1;
    while (idx < n && cyc < 2 * n + 50) begin
      if (bus.out_valid) begin
        bits[idx] = bus.out_bit;
        if (bus.out_last) begin
          nlast++;
          last_idx    = idx;
          rdy_at_last = bus.in_ready;
        end
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    tmo = (idx < n);
    bus.out_ready = 1'b0;
  endtask

  task automatic drain_and_check(input string nm, input logic [NBITS-1:0] d);
    logic [NBITS-1:0] bits;
    int nl, li;
    bit rl, tmo;
    collect(NBITS, bits, nl, li, rl, tmo);
    check({nm, "_timeout"}, NBITS'(tmo), '0);
    check({nm, "_data"}, bits, interleave(d));
    check({nm, "_last_idx"}, NBITS'(li), NBITS'(NBITS - 1));
  endtask

  task automatic run_vec(input int v);
    logic [NBITS-1:0] d, bits, e;
    int nl, li, nacc;
    bit rl, tmo;
    d = '0;
    d[2 * vecs[v].pair + int'(vecs[v].use_even)] = 1'b1;
    e = '0;
    e[vecs[v].exp_k] = 1'b1;
    load_block(d, nacc);
    collect(NBITS, bits, nl, li, rl, tmo);
    check($sformatf("vec%0d_timeout", v), NBITS'(tmo), '0);
    check($sformatf("vec%0d_single_one", v), bits, e);
    check($sformatf("vec%0d_nlast", v), NBITS'(nl), NBITS'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NBITS-1:0] pp_data [3];
    logic [3*NBITS-1:0] pp_bits;
    int pp_last [3];
    int pp_nlast, acc_cyc, first_cyc;
    logic [NBITS-1:0] d0, d1, da, db, dc, bits;
    int nacc, nacc2, nl, li;
    bit a, rl, tmo;
    logic held;

    vecs[0] = '{pair: 0,  use_even: 1'b1, exp_k: 8};
    vecs[1] = '{pair: 8,  use_even: 1'b0, exp_k: 1};
    vecs[2] = '{pair: 0,  use_even: 1'b0, exp_k: 0};
    vecs[3] = '{pair: 63, use_even: 1'b1, exp_k: 127};
    vecs[4] = '{pair: 7,  use_even: 1'b1, exp_k: 120};
    vecs[5] = '{pair: 56, use_even: 1'b0, exp_k: 7};
    vecs[6] = '{pair: 17, use_even: 1'b1, exp_k: 26};

    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_odd = 1'b0; bus.in_even = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready",  NBITS'(bus.in_ready),  NBITS'(1));
    check("rst_out_valid", NBITS'(bus.out_valid), '0);
    check("rst_out_bit",   NBITS'(bus.out_bit),   '0);
    check("rst_out_last",  NBITS'(bus.out_last),  '0);
    check("rst_overflow",  NBITS'(overflow),      '0);

    // Single-one permutation table
    for (int v = 0; v < 7; v++) run_vec(v);

    // Ping-pong: three blocks, one pair every other cycle, out_ready held high
    for (int b = 0; b < 3; b++) pp_data[b] = rand_block();
    acc_cyc = -1; first_cyc = -2; pp_nlast = 0; pp_bits = '0;
    pp_last[0] = -1; pp_last[1] = -1; pp_last[2] = -1;
    fork
      begin
        bit acc;
        int tries;
        for (int b = 0; b < 3; b++) begin
          for (int i = 0; i < NPAIRS; i++) begin
            acc = 1'b0; tries = 0;
            while (!acc && tries < 50) begin
              push_pair(pp_data[b][2*i], pp_data[b][2*i+1], acc);
              tries++;
            end
            if (b == 0 && i == NPAIRS - 1) acc_cyc = cyc_cnt;
            @(posedge clk); #1;
          end
        end
      end
      begin
        int idx = 0;
        int cyc = 0;
        bit seen = 1'b0;
        bus.out_ready = 1'b1;
        while (idx < 3 * NBITS && cyc < 2000) begin
          if (bus.out_valid) begin
            if (!seen) begin seen = 1'b1; first_cyc = cyc_cnt; end
            pp_bits[idx] = bus.out_bit;
            if (bus.out_last) begin
              if (pp_nlast < 3) pp_last[pp_nlast] = idx;
              pp_nlast++;
            end
            idx++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        bus.out_ready = 1'b0;
      end
    join
    check("pp_latency", NBITS'(first_cyc), NBITS'(acc_cyc));
    for (int b = 0; b < 3; b++)
      check($sformatf("pp_blk%0d_data", b), pp_bits[b*NBITS +: NBITS], interleave(pp_data[b]));
    check("pp_nlast", NBITS'(pp_nlast), NBITS'(3));
    check("pp_last0", NBITS'(pp_last[0]), NBITS'(127));
    check("pp_last1", NBITS'(pp_last[1]), NBITS'(255));
    check("pp_last2", NBITS'(pp_last[2]), NBITS'(383));
    check("pp_overflow", NBITS'(overflow), '0);

    // Backpressure and overflow
    d0 = rand_block(); d1 = rand_block();
    bus.out_ready = 1'b0;
    load_block(d0, nacc);
    load_block(d1, nacc2);
    check("bp_accepted", NBITS'(nacc + nacc2), NBITS'(128));
    check("bp_in_ready_low", NBITS'(bus.in_ready), '0);
    check("bp_overflow_pre", NBITS'(overflow), '0);
    push_pair(1'b1, 1'b1, a);
    check("bp_overflow_set", NBITS'(overflow), NBITS'(1));
    held = bus.out_bit;
    repeat (3) @(posedge clk);
    #1;
    check("bp_out_bit_held", NBITS'(bus.out_bit), NBITS'(held));
    bits = interleave(d0);
    check("bp_out_bit0", NBITS'(bus.out_bit), NBITS'(bits[0]));
    collect(NBITS, bits, nl, li, rl, tmo);
    check("bp_blk0_timeout", NBITS'(tmo), '0);
    check("bp_blk0_data", bits, interleave(d0));
    check("bp_rdy_at_last", NBITS'(rl), '0);
    check("bp_rdy_after_last", NBITS'(bus.in_ready), NBITS'(1));
    drain_and_check("bp_blk1", d1);
    check("bp_overflow_sticky", NBITS'(overflow), NBITS'(1));

    // Flush mid-operation: bank 1 half-read, bank 0 partially written
    da = rand_block(); db = rand_block(); dc = rand_block();
    load_block(da, nacc);
    drain_and_check("fl_blkA", da);
    load_block(db, nacc);
    for (int i = 0; i < 30; i++) push_pair(dc[2*i], dc[2*i+1], a);
    collect(64, bits, nl, li, rl, tmo);
    check("fl_half_read", bits, interleave(db) & {{(NBITS-64){1'b0}}, {64{1'b1}}});
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_out_valid", NBITS'(bus.out_valid), '0);
    check("fl_in_ready",  NBITS'(bus.in_ready),  NBITS'(1));
    check("fl_overflow",  NBITS'(overflow),      '0);
    load_block(dc, nacc);
    drain_and_check("fl_new_blk", dc);

    // Asynchronous reset in the middle of a read
    load_block(da, nacc);
    collect(50, bits, nl, li, rl, tmo);
    check("ar_valid_before", NBITS'(bus.out_valid), NBITS'(1));
    #3 rst_n = 1'b0;
    #1;
    check("ar_out_valid", NBITS'(bus.out_valid), '0);
    check("ar_out_bit",   NBITS'(bus.out_bit),   '0);
    check("ar_out_last",  NBITS'(bus.out_last),  '0);
    check("ar_in_ready",  NBITS'(bus.in_ready),  NBITS'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
